wash_phase_timer: RTL

- Timing and program-sequencing stage that sits directly downstream of the wash state controller.
- Consumes the controller's 3-bit state code and a 1 Hz tick enable.
- Produces the controller's inputs initTime, finishTime and hadFinish.
- Also drives the wash/rinse/spin phase sequence, remaining-time display value and motor controls.

---
 rtl/wash_phase_timer_if.sv | 24 ++
 rtl/wash_phase_timer.sv | 107 ++++++++++
 2 files changed

// File: rtl/wash_phase_timer_if.sv
// wash_phase_timer_if: controller-facing bundle of the wash phase timer.
// master drives state/tick/mode select, slave returns countdowns, phase and motor drive.
interface wash_phase_timer_if;
    logic       tick;
    logic [2:0] state;
    logic [1:0] modeSel;
    logic [2:0] initTime;
    logic [2:0] finishTime;
    logic       hadFinish;
    logic [1:0] phase;
    logic [7:0] remainTime;
    logic       motorOn;
    logic       spinFast;
    logic       buzzer;

    modport master (
        output tick, state, modeSel,
        input  initTime, finishTime, hadFinish, phase, remainTime, motorOn, spinFast, buzzer
    );
    modport slave (
        input  tick, state, modeSel,
        output initTime, finishTime, hadFinish, phase, remainTime, motorOn, spinFast, buzzer
    );
endinterface

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: countdowns, wash/rinse/spin sequencing and motor drive behind the wash controller.
// Optional macro FINISH_BUZZER_EN builds a buzzer that toggles on each tick in the finish state.
module wash_phase_timer #(
    parameter int INIT_SEC   = 3,
    parameter int FINISH_SEC = 5,
    parameter int WASH_SEC   = 20,
    parameter int RINSE_SEC  = 15,
    parameter int SPIN_SEC   = 10
) (
    input logic               cp,
    input logic               resetBtn,
    wash_phase_timer_if.slave bus
);
    typedef enum logic [2:0] {
        S_SHUTDOWN = 3'd0,
        S_BEGIN    = 3'd1,
        S_SET      = 3'd2,
        S_RUN      = 3'd3,
        S_ERROR    = 3'd4,
        S_PAUSE    = 3'd5,
        S_FINISH   = 3'd6
    } ctrl_t;

    typedef enum logic [1:0] {WASH = 2'd0, RINSE = 2'd1, SPIN = 2'd2, DONE = 2'd3} phase_t;

    logic [2:0] r_init;
    logic [2:0] r_finish;
    logic       r_had;
    phase_t     r_phase;
    logic [7:0] r_remain;
    logic [1:0] r_mode;
    phase_t     w_first;
    phase_t     w_next;

    function automatic logic [7:0] dur(input phase_t p);
        return p == WASH ? 8'(WASH_SEC) : p == RINSE ? 8'(RINSE_SEC) : p == SPIN ? 8'(SPIN_SEC) : 8'd0;
    endfunction

    // Programs are ascending subsets of WASH/RINSE/SPIN; odd modes skip rinse.
    always_comb begin
        w_first = bus.modeSel == 2'd3 ? SPIN : bus.modeSel == 2'd2 ? RINSE : WASH;
        w_next  = r_phase == WASH ? ((r_mode == 2'd1 || r_mode == 2'd3) ? SPIN : RINSE) :
                  r_phase == RINSE ? SPIN : DONE;
    end

    always_ff @(posedge cp or negedge resetBtn) begin
        if (!resetBtn) begin
            r_init   <= 3'(INIT_SEC);
            r_finish <= 3'(FINISH_SEC);
            r_had    <= 1'b0;
            r_phase  <= WASH;
            r_remain <= 8'd0;
            r_mode   <= 2'd0;
        end else begin
            case (bus.state)
                S_SHUTDOWN: begin
                    r_init   <= 3'(INIT_SEC);
                    r_finish <= 3'(FINISH_SEC);
                    r_had    <= 1'b0;
                    r_phase  <= WASH;
                    r_remain <= 8'd0;
                end
                S_BEGIN: if (bus.tick && r_init != 3'd0) r_init <= r_init - 3'd1;
                S_SET: begin
                    r_mode   <= bus.modeSel;
                    r_phase  <= w_first;
                    r_remain <= dur(w_first);
                    r_had    <= 1'b0;
                    r_finish <= 3'(FINISH_SEC);
                end
                S_RUN: begin
                    r_had <= r_had || r_phase == DONE;
                    // An expired phase advances without waiting for a tick.
                    if (r_remain == 8'd0 && r_phase != DONE) begin
                        r_phase  <= w_next;
                        r_remain <= dur(w_next);
                    end else if (bus.tick && r_remain != 8'd0) begin
                        r_remain <= r_remain - 8'd1;
                    end
                end
                S_FINISH: if (bus.tick && r_finish != 3'd0) r_finish <= r_finish - 3'd1;
                default: ;
            endcase
        end
    end

    assign bus.initTime   = r_init;
    assign bus.finishTime = r_finish;
    assign bus.hadFinish  = r_had;
    assign bus.phase      = r_phase;
    assign bus.remainTime = r_remain;
    assign bus.motorOn    = resetBtn && bus.state == S_RUN && r_phase != DONE;
    assign bus.spinFast   = resetBtn && bus.state == S_RUN && r_phase == SPIN;

`ifdef FINISH_BUZZER_EN
    logic r_buzz;

    always_ff @(posedge cp or negedge resetBtn) begin
        if (!resetBtn) r_buzz <= 1'b0;
        else           r_buzz <= bus.state == S_FINISH ? r_buzz ^ bus.tick : 1'b0;
    end

    assign bus.buzzer = r_buzz && bus.state == S_FINISH;
`else
    assign bus.buzzer = 1'b0;
`endif
endmodule
